// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// CPU-side request/response bundle of the memory access controller.
//   master modport : CPU pipeline (drives requests, receives ready/rdata)
//   slave modport  : mem_access_ctrl (receives requests, returns ready/rdata)
// Signals:
//   cpu_i_req/cpu_i_addr            fetch request and address
//   cpu_i_rdata/cpu_i_ready         fetched word and one-cycle completion pulse
//   cpu_d_rd/cpu_d_wr/cpu_d_addr    load/store request and address
//   cpu_d_wdata                     store data
//   cpu_d_rdata/cpu_d_ready         loaded word and one-cycle completion pulse
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int WORD_SIZE = 16
);
  logic                 cpu_i_req;
  logic [WORD_SIZE-1:0] cpu_i_addr;
  logic [WORD_SIZE-1:0] cpu_i_rdata;
  logic                 cpu_i_ready;
  logic                 cpu_d_rd;
  logic                 cpu_d_wr;
  logic [WORD_SIZE-1:0] cpu_d_addr;
  logic [WORD_SIZE-1:0] cpu_d_wdata;
  logic [WORD_SIZE-1:0] cpu_d_rdata;
  logic                 cpu_d_ready;

  modport master (
    output cpu_i_req, cpu_i_addr, cpu_d_rd, cpu_d_wr, cpu_d_addr, cpu_d_wdata,
    input  cpu_i_rdata, cpu_i_ready, cpu_d_rdata, cpu_d_ready
  );

  modport slave (
    input  cpu_i_req, cpu_i_addr, cpu_d_rd, cpu_d_wr, cpu_d_addr, cpu_d_wdata,
    output cpu_i_rdata, cpu_i_ready, cpu_d_rdata, cpu_d_ready
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Initiator side of a dual-port (instruction/data) multi-cycle memory bus.
// Takes fetch and load/store requests from the CPU, drives the memory strobes,
// addresses and store data for MEM_LATENCY cycles, captures read data and
// returns a one-cycle ready pulse per completed port. Instruction and data
// accesses are launched in lockstep because the memory shares one access
// counter between its ports.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   cpu (slave modport)   CPU request/response bundle (mem_access_ctrl_if)
//   i_readM/i_writeM      instruction-port strobes (i_writeM tied 0)
//   i_address/i_data      instruction-port address; i_data never driven
//   d_readM/d_writeM      data-port strobes
//   d_address/d_data      data-port address; d_data driven only during writes
//   stat_fetches/loads/stores  saturating access counters (optional)
//
// Optional feature: define MEMCTRL_STATS_EN to add the stat_* counter outputs.
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 3,
  parameter int CNT_W       = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_access_ctrl_if.slave     cpu,
  output logic                 i_readM,
  output logic                 i_writeM,
  output logic [WORD_SIZE-1:0] i_address,
  inout  wire  [WORD_SIZE-1:0] i_data,
  output logic                 d_readM,
  output logic                 d_writeM,
  output logic [WORD_SIZE-1:0] d_address,
  inout  wire  [WORD_SIZE-1:0] d_data
`ifdef MEMCTRL_STATS_EN
  ,
  output logic [15:0]          stat_fetches,
  output logic [15:0]          stat_loads,
  output logic [15:0]          stat_stores
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 i_act;       // fetch part of the in-flight access
  logic                 d_rd_act;    // load part of the in-flight access
  logic                 d_wr_act;    // store part of the in-flight access
  logic [WORD_SIZE-1:0] store_data;  // store data latched at launch

  // The controller never drives the instruction data bus.
  assign i_data   = {WORD_SIZE{1'bz}};
  // Store data goes onto the data bus only while the write strobe is up.
  assign d_data   = d_writeM ? store_data : {WORD_SIZE{1'bz}};
  assign i_writeM = 1'b0;

  // Access sequencer: launch, hold for MEM_LATENCY cycles, capture, pulse ready.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= {CNT_W{1'b0}};
      i_act           <= 1'b0;
      d_rd_act        <= 1'b0;
      d_wr_act        <= 1'b0;
      store_data      <= {WORD_SIZE{1'b0}};
      i_readM         <= 1'b0;
      d_readM         <= 1'b0;
      d_writeM        <= 1'b0;
      i_address       <= {WORD_SIZE{1'b0}};
      d_address       <= {WORD_SIZE{1'b0}};
      cpu.cpu_i_rdata <= {WORD_SIZE{1'b0}};
      cpu.cpu_d_rdata <= {WORD_SIZE{1'b0}};
      cpu.cpu_i_ready <= 1'b0;
      cpu.cpu_d_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu.cpu_i_ready <= 1'b0;
          cpu.cpu_d_ready <= 1'b0;
          if (cpu.cpu_i_req || cpu.cpu_d_rd || cpu.cpu_d_wr) begin
            // All pending ports launch together; a store beats a load.
            i_act      <= cpu.cpu_i_req;
            d_rd_act   <= cpu.cpu_d_rd & ~cpu.cpu_d_wr;
            d_wr_act   <= cpu.cpu_d_wr;
            i_readM    <= cpu.cpu_i_req;
            d_readM    <= cpu.cpu_d_rd & ~cpu.cpu_d_wr;
            d_writeM   <= cpu.cpu_d_wr;
            i_address  <= cpu.cpu_i_addr;
            d_address  <= cpu.cpu_d_addr;
            store_data <= cpu.cpu_d_wdata;
            cnt        <= {CNT_W{1'b0}};
            state      <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt == LAST_CNT) begin
            if (i_act) begin
              cpu.cpu_i_rdata <= i_data;
            end else begin
              cpu.cpu_i_rdata <= cpu.cpu_i_rdata;
            end
            if (d_rd_act) begin
              cpu.cpu_d_rdata <= d_data;
            end else begin
              cpu.cpu_d_rdata <= cpu.cpu_d_rdata;
            end
            // Ready is registered here so it is high exactly in the DONE cycle.
            cpu.cpu_i_ready <= i_act;
            cpu.cpu_d_ready <= d_rd_act | d_wr_act;
            i_readM         <= 1'b0;
            d_readM         <= 1'b0;
            d_writeM        <= 1'b0;
            cnt             <= {CNT_W{1'b0}};
            state           <= DONE;
          end else begin
            cnt   <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            state <= ACCESS;
          end
        end
        DONE: begin
          cpu.cpu_i_ready <= 1'b0;
          cpu.cpu_d_ready <= 1'b0;
          i_act           <= 1'b0;
          d_rd_act        <= 1'b0;
          d_wr_act        <= 1'b0;
          state           <= IDLE;
        end
        default: begin
          i_readM         <= 1'b0;
          d_readM         <= 1'b0;
          d_writeM        <= 1'b0;
          cpu.cpu_i_ready <= 1'b0;
          cpu.cpu_d_ready <= 1'b0;
          cnt             <= {CNT_W{1'b0}};
          state           <= IDLE;
        end
      endcase
    end
  end

`ifdef MEMCTRL_STATS_EN
  // Saturating per-kind counters, bumped once per completed access in DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_fetches <= 16'h0000;
      stat_loads   <= 16'h0000;
      stat_stores  <= 16'h0000;
    end else if (state == DONE) begin
      if (i_act && (stat_fetches != 16'hFFFF)) begin
        stat_fetches <= stat_fetches + 16'd1;
      end else begin
        stat_fetches <= stat_fetches;
      end
      if (d_rd_act && (stat_loads != 16'hFFFF)) begin
        stat_loads <= stat_loads + 16'd1;
      end else begin
        stat_loads <= stat_loads;
      end
      if (d_wr_act && (stat_stores != 16'hFFFF)) begin
        stat_stores <= stat_stores + 16'd1;
      end else begin
        stat_stores <= stat_stores;
      end
    end else begin
      stat_fetches <= stat_fetches;
      stat_loads   <= stat_loads;
      stat_stores  <= stat_stores;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl with a small behavioural memory on both
// ports. Cycle numbers in the tasks count clock edges after the request is
// raised: cycle 1 is the first cycle after the launch edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  logic        clk;
  logic        reset_n;
  logic        i_readM, i_writeM, d_readM, d_writeM;
  logic [15:0] i_address, d_address;
  wire  [15:0] i_data;
  wire  [15:0] d_data;
`ifdef MEMCTRL_STATS_EN
  logic [15:0] stat_fetches, stat_loads, stat_stores;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_ctrl_if #(.WORD_SIZE(16)) cpu();

  mem_access_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu       (cpu),
    .i_readM   (i_readM),
    .i_writeM  (i_writeM),
    .i_address (i_address),
    .i_data    (i_data),
    .d_readM   (d_readM),
    .d_writeM  (d_writeM),
    .d_address (d_address),
    .d_data    (d_data)
`ifdef MEMCTRL_STATS_EN
    ,
    .stat_fetches (stat_fetches),
    .stat_loads   (stat_loads),
    .stat_stores  (stat_stores)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: fixed contents plus one writable location.
  logic [15:0] wmem_addr  = 16'h0000;
  logic [15:0] wmem_data  = 16'h0000;
  logic        wmem_valid = 1'b0;

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (wmem_valid && a == wmem_addr) return wmem_data;
    case (a)
      16'h0000: return 16'h9023;
      16'h0001: return 16'h0001;
      16'h0002: return 16'hFFFF;
      16'h0023: return 16'h6000;
      default:  return 16'h0000;
    endcase
  endfunction

  assign i_data = i_readM ? mem_read(i_address) : 16'hzzzz;
  assign d_data = d_readM ? mem_read(d_address) : 16'hzzzz;

  always @(posedge clk) begin
    if (d_writeM) begin
      wmem_addr  <= d_address;
      wmem_data  <= d_data;
      wmem_valid <= 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cpu.cpu_i_req = 1'b0; cpu.cpu_i_addr = 16'h0000;
    cpu.cpu_d_rd = 1'b0; cpu.cpu_d_wr = 1'b0;
    cpu.cpu_d_addr = 16'h0000; cpu.cpu_d_wdata = 16'h0000;
    tick(); tick();
    n_tests++;
    if ({i_readM, i_writeM, d_readM, d_writeM, cpu.cpu_i_ready, cpu.cpu_d_ready} !== 6'b000000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
        {i_readM, i_writeM, d_readM, d_writeM, cpu.cpu_i_ready, cpu.cpu_d_ready});
    end
    n_tests++;
    if ({cpu.cpu_i_rdata, cpu.cpu_d_rdata, i_address, d_address} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0",
        {cpu.cpu_i_rdata, cpu.cpu_d_rdata, i_address, d_address});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch;
    cpu.cpu_i_addr = 16'h0000; cpu.cpu_i_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_tests++;
      if (i_readM !== (c >= 1 && c <= 3) || cpu.cpu_i_ready !== (c == 4) || d_readM !== 1'b0 || i_writeM !== 1'b0) begin
        n_fail++; $display("FAIL fetch_cyc%0d: i_readM=%b ready=%b d_readM=%b i_writeM=%b want %b %b 0 0",
          c, i_readM, cpu.cpu_i_ready, d_readM, i_writeM, (c >= 1 && c <= 3), (c == 4));
      end
      if (c == 4) begin
        n_tests++;
        if (cpu.cpu_i_rdata !== 16'h9023) begin
          n_fail++; $display("FAIL fetch_rdata: got %h want 9023", cpu.cpu_i_rdata);
        end
        cpu.cpu_i_req = 1'b0;
      end
    end
  endtask

  task automatic test_load;
    cpu.cpu_d_addr = 16'h0002; cpu.cpu_d_rd = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_tests++;
      if (d_readM !== (c >= 1 && c <= 3) || cpu.cpu_d_ready !== (c == 4) || i_readM !== 1'b0 || d_writeM !== 1'b0) begin
        n_fail++; $display("FAIL load_cyc%0d: d_readM=%b ready=%b i_readM=%b d_writeM=%b want %b %b 0 0",
          c, d_readM, cpu.cpu_d_ready, i_readM, d_writeM, (c >= 1 && c <= 3), (c == 4));
      end
      if (c == 4) begin
        n_tests++;
        if (cpu.cpu_d_rdata !== 16'hFFFF) begin
          n_fail++; $display("FAIL load_rdata: got %h want ffff", cpu.cpu_d_rdata);
        end
        cpu.cpu_d_rd = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back;
    cpu.cpu_d_addr = 16'h0010; cpu.cpu_d_wdata = 16'hBEEF; cpu.cpu_d_wr = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      n_tests++;
      if (d_writeM !== (c >= 1 && c <= 3) || d_readM !== (c >= 6 && c <= 8) ||
          cpu.cpu_d_ready !== (c == 4 || c == 9)) begin
        n_fail++; $display("FAIL b2b_cyc%0d: d_writeM=%b d_readM=%b ready=%b want %b %b %b",
          c, d_writeM, d_readM, cpu.cpu_d_ready, (c >= 1 && c <= 3), (c >= 6 && c <= 8), (c == 4 || c == 9));
      end
      if (c >= 1 && c <= 3) begin
        n_tests++;
        if (d_data !== 16'hBEEF) begin
          n_fail++; $display("FAIL b2b_wbus_cyc%0d: got %h want beef", c, d_data);
        end
      end
      if (c == 4) begin
        cpu.cpu_d_wr = 1'b0; cpu.cpu_d_rd = 1'b1;
      end
      if (c == 9) begin
        n_tests++;
        if (cpu.cpu_d_rdata !== 16'hBEEF) begin
          n_fail++; $display("FAIL b2b_rdata: got %h want beef", cpu.cpu_d_rdata);
        end
        cpu.cpu_d_rd = 1'b0;
      end
    end
  endtask

  task automatic test_dual;
    cpu.cpu_i_addr = 16'h0023; cpu.cpu_i_req = 1'b1;
    cpu.cpu_d_addr = 16'h0001; cpu.cpu_d_rd = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_tests++;
      if (i_readM !== (c >= 1 && c <= 3) || d_readM !== (c >= 1 && c <= 3) ||
          cpu.cpu_i_ready !== (c == 4) || cpu.cpu_d_ready !== (c == 4)) begin
        n_fail++; $display("FAIL dual_cyc%0d: i_readM=%b d_readM=%b i_rdy=%b d_rdy=%b want %b %b %b %b",
          c, i_readM, d_readM, cpu.cpu_i_ready, cpu.cpu_d_ready,
          (c >= 1 && c <= 3), (c >= 1 && c <= 3), (c == 4), (c == 4));
      end
      if (c == 4) begin
        n_tests++;
        if (cpu.cpu_i_rdata !== 16'h6000 || cpu.cpu_d_rdata !== 16'h0001) begin
          n_fail++; $display("FAIL dual_rdata: got %h %h want 6000 0001", cpu.cpu_i_rdata, cpu.cpu_d_rdata);
        end
        cpu.cpu_i_req = 1'b0; cpu.cpu_d_rd = 1'b0;
      end
    end
  endtask

  task automatic test_deferred;
    cpu.cpu_i_addr = 16'h0000; cpu.cpu_i_req = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      n_tests++;
      if (i_readM !== (c >= 1 && c <= 3) || d_readM !== (c >= 6 && c <= 8) ||
          cpu.cpu_i_ready !== (c == 4) || cpu.cpu_d_ready !== (c == 9)) begin
        n_fail++; $display("FAIL defer_cyc%0d: i_readM=%b d_readM=%b i_rdy=%b d_rdy=%b want %b %b %b %b",
          c, i_readM, d_readM, cpu.cpu_i_ready, cpu.cpu_d_ready,
          (c >= 1 && c <= 3), (c >= 6 && c <= 8), (c == 4), (c == 9));
      end
      if (c == 2) begin
        cpu.cpu_d_addr = 16'h0002; cpu.cpu_d_rd = 1'b1;
      end
      if (c == 4) cpu.cpu_i_req = 1'b0;
      if (c == 9) begin
        n_tests++;
        if (cpu.cpu_d_rdata !== 16'hFFFF || cpu.cpu_i_rdata !== 16'h9023) begin
          n_fail++; $display("FAIL defer_rdata: got %h %h want ffff 9023", cpu.cpu_d_rdata, cpu.cpu_i_rdata);
        end
        cpu.cpu_d_rd = 1'b0;
      end
    end
  endtask

  task automatic test_rd_wr_both;
    cpu.cpu_d_addr = 16'h0020; cpu.cpu_d_wdata = 16'h1234;
    cpu.cpu_d_rd = 1'b1; cpu.cpu_d_wr = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_tests++;
      if (d_writeM !== (c >= 1 && c <= 3) || d_readM !== 1'b0 || cpu.cpu_d_ready !== (c == 4)) begin
        n_fail++; $display("FAIL rdwr_cyc%0d: d_writeM=%b d_readM=%b ready=%b want %b 0 %b",
          c, d_writeM, d_readM, cpu.cpu_d_ready, (c >= 1 && c <= 3), (c == 4));
      end
      if (c == 4) begin
        cpu.cpu_d_rd = 1'b0; cpu.cpu_d_wr = 1'b0;
      end
    end
    n_tests++;
    if (wmem_data !== 16'h1234 || wmem_addr !== 16'h0020) begin
      n_fail++; $display("FAIL rdwr_memwrite: got %h@%h want 1234@0020", wmem_data, wmem_addr);
    end
`ifdef MEMCTRL_STATS_EN
    n_tests++;
    if (stat_fetches !== 16'd3 || stat_loads !== 16'd4 || stat_stores !== 16'd2) begin
      n_fail++; $display("FAIL stats_count: got %0d %0d %0d want 3 4 2", stat_fetches, stat_loads, stat_stores);
    end
`endif
  endtask

  task automatic test_reset_mid;
    cpu.cpu_i_addr = 16'h0023; cpu.cpu_i_req = 1'b1;
    tick(); tick();
    n_tests++;
    if (i_readM !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: i_readM=%b want 1", i_readM);
    end
    reset_n = 1'b0; cpu.cpu_i_req = 1'b0;
    tick();
    n_tests++;
    if ({i_readM, d_readM, d_writeM, cpu.cpu_i_ready, cpu.cpu_d_ready} !== 5'b00000 ||
        cpu.cpu_i_rdata !== 16'h0000 || cpu.cpu_d_rdata !== 16'h0000) begin
      n_fail++; $display("FAIL rstmid_clear: ctl=%b i_rdata=%h d_rdata=%h want 00000 0000 0000",
        {i_readM, d_readM, d_writeM, cpu.cpu_i_ready, cpu.cpu_d_ready}, cpu.cpu_i_rdata, cpu.cpu_d_rdata);
    end
`ifdef MEMCTRL_STATS_EN
    n_tests++;
    if (stat_fetches !== 16'd0 || stat_loads !== 16'd0 || stat_stores !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_stats: got %0d %0d %0d want 0 0 0", stat_fetches, stat_loads, stat_stores);
    end
`endif
    reset_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_tests++;
      if ({i_readM, d_readM, d_writeM, cpu.cpu_i_ready, cpu.cpu_d_ready} !== 5'b00000) begin
        n_fail++; $display("FAIL rstmid_quiet_cyc%0d: ctl=%b want 00000", c,
          {i_readM, d_readM, d_writeM, cpu.cpu_i_ready, cpu.cpu_d_ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_back_to_back();
    test_dual();
    test_deferred();
    test_rd_wr_both();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the dual-port (instruction/data) multi-cycle memory bus.
- Accepts fetch requests from the CPU fetch stage and load/store requests from the CPU memory stage.
- Drives the readM/writeM/address strobes and the bidirectional data buses, holds them for the fixed memory access period, captures read data, and returns a one-cycle ready pulse.
- Launches instruction and data accesses in lockstep, because the memory uses one shared access counter for both ports.

Parameters:
- WORD_SIZE, 16, width of addresses and data words.
- MEM_LATENCY, 3, cycles a strobe is held per access; must equal the memory's access period.
- CNT_W, 2, width of the latency counter; must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  synchronous active-low reset, sampled on posedge clk.
- cpu_i_req  in  1  fetch request, held high until cpu_i_ready.
- cpu_i_addr  in  WORD_SIZE  fetch address.
- cpu_i_rdata  out  WORD_SIZE  fetched word, valid when cpu_i_ready=1, held until the next capture.
- cpu_i_ready  out  1  one-cycle completion pulse for a fetch.
- cpu_d_rd  in  1  load request.
- cpu_d_wr  in  1  store request.
- cpu_d_addr  in  WORD_SIZE  load/store address.
- cpu_d_wdata  in  WORD_SIZE  store data.
- cpu_d_rdata  out  WORD_SIZE  loaded word.
- cpu_d_ready  out  1  one-cycle completion pulse for a load or store.
- i_readM  out  1  instruction-port read strobe.
- i_writeM  out  1  instruction-port write strobe; always 0.
- i_address  out  WORD_SIZE  instruction-port address.
- i_data  inout  WORD_SIZE  instruction-port data; never driven, always 'z.
- d_readM  out  1  data-port read strobe.
- d_writeM  out  1  data-port write strobe.
- d_address  out  WORD_SIZE  data-port address.
- d_data  inout  WORD_SIZE  data-port data; driven with the latched store data only while d_writeM=1, else 'z.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is synchronous and active-low (reset_n).
  - While reset_n=0, at each posedge: state=IDLE, cnt=0, all strobes 0, both ready outputs 0, both rdata outputs 0, addresses 0.
- State machine, states IDLE, ACCESS, DONE:
  - IDLE: sample the requests. If cpu_i_req, or cpu_d_rd, or cpu_d_wr is high:
    - latch the addresses and store data;
    - set the strobes of every pending port simultaneously;
    - cnt=0; go to ACCESS.
  - ACCESS: hold the strobes, addresses and write data constant; cnt increments each cycle.
    - On the posedge ending the cycle where cnt==MEM_LATENCY-1, capture i_data into cpu_i_rdata (if a fetch is active) and d_data into cpu_d_rdata (if a load is active).
    - On that same edge, drop all strobes and go to DONE.
  - DONE: assert cpu_i_ready and/or cpu_d_ready for exactly this cycle, only for the ports that were active. Next state is IDLE.
- Latency:
  - Requester contract: the request is asserted before edge E0 and is seen in IDLE. Strobes are high for cycles 1..MEM_LATENCY. Ready is high in cycle MEM_LATENCY+1 (cycle 4 with default).
  - The requester deasserts its request on the edge that ends the ready cycle. A request still high when IDLE is re-entered is a new access.
  - Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Arbitration:
  - A request arriving while in ACCESS or DONE is not joined to the in-flight access; it waits for IDLE.
  - This keeps the memory's shared counter aligned, since its strobes always rise and fall together.
- cpu_d_rd and cpu_d_wr both high: the write wins and the read is ignored; cpu_d_ready still pulses once.
- Strobes are registered outputs; there is no combinational path from the CPU inputs to the memory strobes.
- Reset mid-ACCESS: the access is abandoned, no ready pulse is issued, and rdata is cleared. The memory must be reset in the same cycles.

Optional Feature:
- Macro MEMCTRL_STATS_EN.
- Defined:
  - Adds outputs stat_fetches, stat_loads, stat_stores (each 16 bits).
  - Each counter increments by one in the DONE cycle of the matching access and saturates at 16'hFFFF.
  - All three are cleared by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- After reset, cpu_i_req with addr 16'h0000 -> i_readM high for exactly 3 cycles; cpu_i_ready pulses in cycle 4 with cpu_i_rdata=16'h9023; i_data is never driven.
- cpu_d_rd with addr 16'h0002 -> cpu_d_ready in cycle 4 with cpu_d_rdata=16'hFFFF; d_data is 'z from the controller throughout.
- cpu_d_wr with addr 16'h0010 and data 16'hBEEF, then cpu_d_rd with addr 16'h0010 -> d_data=16'hBEEF only while d_writeM=1; the read returns 16'hBEEF; the second access starts 5 cycles after the first.
- cpu_i_req addr 16'h0023 and cpu_d_rd addr 16'h0001 in the same cycle -> both strobes rise and fall on identical edges; both readies pulse in the same cycle with 16'h6000 and 16'h0001.
- Fetch in flight and cpu_d_rd raised in the 2nd ACCESS cycle -> the load launches only after DONE→IDLE; no overlap of i_readM and d_readM windows.
- reset_n low during the 2nd ACCESS cycle -> all strobes 0 at the next edge, no ready pulse, rdata=0; with MEMCTRL_STATS_EN defined, all stats read 0.
